// File: rtl/frame_sched_if.sv
// Control/status bundle between the register block, the LED serializer and frame_sched.
// master = register/serializer side, slave = the scheduler.
interface frame_sched_if #(
  parameter int PIX_W = 10,
  parameter int PER_W = 16
);
  logic             enable_i;
  logic             auto_i;
  logic             start_i;
  logic [PIX_W-1:0] frame_pixels_i;
  logic [PER_W-1:0] frame_period_i;
  logic             pix_wr_i;
  logic             ser_re_i;
  logic             ser_eof_i;
  logic             skip_clr_i;
  logic             run_o;
  logic             busy_o;
  logic             frame_done_o;
  logic [7:0]       frame_cnt_o;
  logic             skip_o;

  modport master (
    output enable_i, auto_i, start_i, frame_pixels_i, frame_period_i,
           pix_wr_i, ser_re_i, ser_eof_i, skip_clr_i,
    input  run_o, busy_o, frame_done_o, frame_cnt_o, skip_o
  );

  modport slave (
    input  enable_i, auto_i, start_i, frame_pixels_i, frame_period_i,
           pix_wr_i, ser_re_i, ser_eof_i, skip_clr_i,
    output run_o, busy_o, frame_done_o, frame_cnt_o, skip_o
  );
endinterface

// File: rtl/frame_sched.sv
// Frame scheduler for the LED serializer: starts a frame only once a whole frame is
// buffered, on manual request or periodic refresh, and waits for end-of-frame.
module frame_sched #(
  parameter int PIX_W    = 10,
  parameter int PER_W    = 16,
  parameter int PRESCALE = 44
) (
  input logic          clk,
  input logic          rst_n,
  frame_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_WAIT_EOF} state_e;

  localparam logic [7:0]     PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [PIX_W:0] PEND_ONE   = (PIX_W+1)'(1);
  localparam logic [PIX_W:0] PEND_MAX   = '1;
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;
  localparam logic [PIX_W-1:0] CONS_ONE = PIX_W'(1);

  state_e           state_q, state_d;
  logic [PIX_W:0]   pend_q, pend_d;
  logic [PIX_W-1:0] cons_q, cons_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             latch_q, latch_d;
  logic             skip_q, skip_d;
  logic             done_q, done_d;

  logic enable, auto_mode, waiting;
  logic ready, expired, tick, request, go, skip_evt, eof_evt, last_read;

  assign enable    = bus.enable_i;
  assign auto_mode = bus.auto_i;
  assign waiting   = (state_q == S_WAIT);

  assign ready   = (bus.frame_pixels_i != '0) && (pend_q >= {1'b0, bus.frame_pixels_i});
  assign expired = (bus.frame_period_i == '0) || (per_q >= bus.frame_period_i);
  assign tick    = (state_q != S_IDLE) && (presc_q == PRESC_LAST);

  // A START in the very cycle the frame can start is served directly and merges into it.
  assign request   = auto_mode ? expired : (latch_q || bus.start_i);
  assign go        = enable && waiting && ready && request;
  assign skip_evt  = enable && waiting && auto_mode && expired && !ready;
  assign eof_evt   = enable && (state_q == S_WAIT_EOF) && bus.ser_eof_i;
  assign last_read = bus.ser_re_i &&
                     (({1'b0, cons_q} + PEND_ONE) >= {1'b0, bus.frame_pixels_i});

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_WAIT;
        S_WAIT:     if (go) state_d = S_RUN;
        S_RUN:      if (last_read) state_d = S_WAIT_EOF;
        S_WAIT_EOF: if (bus.ser_eof_i) state_d = S_WAIT;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pend_d  = pend_q;
    cons_d  = cons_q;
    per_d   = per_q;
    presc_d = presc_q;
    latch_d = latch_q;
    if (!enable) begin
      pend_d  = '0;
      cons_d  = '0;
      per_d   = '0;
      presc_d = '0;
      latch_d = 1'b0;
    end else begin
      if (bus.pix_wr_i && !bus.ser_re_i && pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_ONE;
      end else if (bus.ser_re_i && !bus.pix_wr_i && pend_q != '0) begin
        pend_d = pend_q - PEND_ONE;
      end

      presc_d = (state_q == S_IDLE || tick) ? 8'd0 : presc_q + 8'd1;

      if (go || skip_evt)             per_d = '0;
      else if (tick && per_q != PER_MAX) per_d = per_q + PER_ONE;

      if (go)                                    cons_d = '0;
      else if (state_q == S_RUN && bus.ser_re_i) cons_d = cons_q + CONS_ONE;

      if (go)                               latch_d = 1'b0;
      else if (bus.start_i && !auto_mode)   latch_d = 1'b1;
    end
  end

  // Skip event beats a simultaneous clear; SKIP and FRAME_CNT survive ENABLE low.
  assign skip_d = skip_evt ? 1'b1 : (bus.skip_clr_i ? 1'b0 : skip_q);
  assign done_d = eof_evt;
  assign cnt_d  = cnt_q + {7'd0, eof_evt};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cons_q  <= '0;
      per_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      latch_q <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cons_q  <= cons_d;
      per_q   <= per_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
    end
  end

  assign bus.run_o        = (state_q == S_RUN);
  assign bus.busy_o       = (state_q == S_RUN) || (state_q == S_WAIT_EOF);
  assign bus.frame_done_o = done_q;
  assign bus.frame_cnt_o  = cnt_q;
  assign bus.skip_o       = skip_q;

endmodule
